byte_receiver: RTL

RS-232 receive path: the counterpart to `byte_transmitter` on the same serial link, 8N1, LSB first. It oversamples the asynchronous `rs232_rx` line at 16× baud, validates the start bit, and majority-votes each bit. Completed bytes go into a one-deep holding register with a valid/ack handshake, so the CPU/IO side can consume host input on `global_clk`.

---
 rtl/rs232_pkg.sv | 21 ++
 rtl/rs232_oversample_tick.sv | 22 ++
 rtl/byte_receiver.sv | 94 +++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// rs232_pkg: state encodings, oversampling constants and baud divider helper shared by the RS-232 blocks.
package rs232_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam logic [3:0] SC_VOTE_A = 4'd7;
    localparam logic [3:0] SC_VOTE_B = 4'd8;
    localparam logic [3:0] SC_VOTE_C = 4'd9;
    localparam logic [3:0] SC_LAST   = 4'd15;

    // Rounded clk_hz/(baud*os), never below 1.
    function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
        longint t;
        longint d;
        t = baud * os;
        d = (clk_hz + t / 2) / t;
        return d < 1 ? 1 : int'(d);
    endfunction

endpackage

// File: rtl/rs232_oversample_tick.sv
// rs232_oversample_tick: emits a one-clk tick every DIV clocks, phase reset by clr.
module rs232_oversample_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/byte_receiver.sv
// byte_receiver: 8N1 RS-232 receiver with 16x oversampling, 2-of-3 vote and a one-deep valid/ack holding register.
module byte_receiver #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    import rs232_pkg::*;

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);

    rx_state_t  state, state_n;
    logic       rx_meta, rxs, tick, s7, s8, vote, mid, last, deliver, frame_err_n;
    logic [3:0] sc;
    logic [2:0] bi;
    logic [7:0] sr;

    // Divider held cleared while idle so tick phase follows the start edge.
    rs232_oversample_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

    assign vote        = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
    assign mid         = tick && sc == SC_VOTE_C;
    assign last        = tick && sc == SC_LAST;
    assign deliver     = state == STOP && mid && vote;
    assign frame_err_n = state == STOP && mid && !vote;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = !rxs ? START : IDLE;
            START:     state_n = (mid && vote) ? IDLE : last ? DATA : START;
            DATA:      state_n = (last && bi == 3'd7) ? STOP : DATA;
            STOP:      state_n = mid ? (vote ? IDLE : WAIT_HIGH) : STOP;
            WAIT_HIGH: state_n = rxs ? IDLE : WAIT_HIGH;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            state        <= IDLE;
            sc           <= '0;
            bi           <= '0;
            sr           <= '0;
            s7           <= 1'b1;
            s8           <= 1'b1;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_meta      <= rs232_rx;
            rxs          <= rx_meta;
            state        <= state_n;
            rx_frame_err <= frame_err_n;
            sc           <= state == IDLE ? 4'd0 : tick ? sc + 4'd1 : sc;
            if (tick && sc == SC_VOTE_A)
                s7 <= rxs;
            if (tick && sc == SC_VOTE_B)
                s8 <= rxs;
            if (state != DATA)
                bi <= '0;
            else if (last)
                bi <= bi + 3'd1;
            // LSB arrives first, so each new bit enters at the top.
            if (state == DATA && mid)
                sr <= {vote, sr[7:1]};
            if (deliver && (!rx_valid || rx_ack)) begin
                rx_byte  <= sr;
                rx_valid <= 1'b1;
            end else if (deliver) begin
                rx_overrun <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end
endmodule
